// File: rtl/ysyx_22040127_arb_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package ysyx_22040127_arb_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned GNT_IF          = 0;
  localparam int unsigned GNT_LS          = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22040127_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester that did not win last.
module ysyx_22040127_rr_arb2
  import ysyx_22040127_arb_pkg::*;
(
  input  logic       valid_if,
  input  logic       valid_ls,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid_if && valid_ls) begin
      if (last_grant == OWN_IF) grant[GNT_LS] = 1'b1;
      else                      grant[GNT_IF] = 1'b1;
    end else if (valid_if) begin
      grant[GNT_IF] = 1'b1;
    end else if (valid_ls) begin
      grant[GNT_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22040127_mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one memory port,
// one outstanding transaction at a time, with a response timeout.
module ysyx_22040127_mem_arbiter
  import ysyx_22040127_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic        if_resp_err,
  output logic [63:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_addr,
  input  logic        ls_we,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_resp_valid,
  output logic        ls_resp_err,
  output logic [63:0] ls_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_rdata
);

  state_e           state_q, state_d;
  owner_e           owner_q, last_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant;
  logic             accept_if, accept_ls;
  logic             done, done_err;

  ysyx_22040127_rr_arb2 u_rr (
    .valid_if   (if_req_valid),
    .valid_ls   (ls_req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign if_req_ready  = (state_q == S_IDLE) && grant[GNT_IF];
  assign ls_req_ready  = (state_q == S_IDLE) && grant[GNT_LS];
  assign mem_req_valid = (state_q == S_REQ);

  // Next state, timeout counter and completion strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_if = 1'b0;
    accept_ls = 1'b0;
    done      = 1'b0;
    done_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept_if = if_req_ready;
        accept_ls = ls_req_ready;
        if (accept_if || accept_ls) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        // A real response beats a timeout landing on the same cycle
        if (mem_resp_valid) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_IDLE;
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_IF;
      last_q        <= OWN_IF;
      cnt_q         <= '0;
      if_resp_valid <= 1'b0;
      if_resp_err   <= 1'b0;
      if_rdata      <= '0;
      ls_resp_valid <= 1'b0;
      ls_resp_err   <= 1'b0;
      ls_rdata      <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      if_resp_valid <= done && (owner_q == OWN_IF);
      ls_resp_valid <= done && (owner_q == OWN_LS);

      // Response payload holds between pulses
      if (done && (owner_q == OWN_IF)) begin
        if_resp_err <= done_err;
        if_rdata    <= done_err ? 64'h0 : mem_rdata;
      end
      if (done && (owner_q == OWN_LS)) begin
        ls_resp_err <= done_err;
        ls_rdata    <= (done_err || mem_we) ? 64'h0 : mem_rdata;
      end

      if (accept_if) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
        mem_wmask <= '0;
        owner_q   <= OWN_IF;
        last_q    <= OWN_IF;
      end else if (accept_ls) begin
        mem_addr  <= ls_addr;
        mem_we    <= ls_we;
        mem_wdata <= ls_wdata;
        mem_wmask <= ls_wmask;
        owner_q   <= OWN_LS;
        last_q    <= OWN_LS;
      end
    end
  end

endmodule

// File: doc/ysyx_22040127_mem_arbiter.md
YSYX_22040127_MEM_ARBITER -- requirements
Module: ysyx_22040127_mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 255, cycles to wait in RESP before an error response (8-bit counter).
REQ-002 Reset SHALL be synchronous and active-high on a single clock; ports SHALL be, in order:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  64  fetch address
- if_resp_valid  out  1  fetch response pulse
- if_resp_err  out  1  fetch response was a timeout
- if_rdata  out  64  fetch read data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store accepted this cycle
- ls_addr  in  64  load/store address
- ls_we  in  1  1 = store
- ls_wdata  in  64  store data
- ls_wmask  in  8  store byte mask
- ls_resp_valid  out  1  load/store response pulse
- ls_resp_err  out  1  load/store response was a timeout
- ls_rdata  out  64  load data
- mem_req_valid  out  1  request to shared memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_we, mem_wdata, mem_wmask  out  64/1/64/8  latched request fields
- mem_resp_valid  in  1  memory response/ack
- mem_rdata  in  64  memory read data

Function
REQ-003 The FSM SHALL have states IDLE, REQ and RESP, plus a 1-bit owner register (IF/LS) and a 1-bit last-grant register.
REQ-004 In IDLE, grant SHALL be combinational:
- only one valid: grant it;
- both valid: grant the requester that is not last-grant.
REQ-005 if_req_ready/ls_req_ready SHALL be high only in IDLE, for the granted requester only; both SHALL be 0 in REQ and RESP.
REQ-006 On acceptance (valid && ready), the block SHALL:
- latch addr, we, wdata and wmask into mem_* registers (an IF request latches we=0, wmask=0, wdata=0);
- set owner and last-grant;
- enter REQ.
REQ-007 In REQ, mem_req_valid SHALL be 1 with all mem_* fields stable; on mem_req_ready the FSM SHALL enter RESP and clear the timeout counter.
REQ-008 mem_req_valid SHALL be 0 in IDLE and RESP.
REQ-009 In RESP, on mem_resp_valid the FSM SHALL return to IDLE.
- The owner's resp_valid SHALL pulse for exactly one cycle on the next cycle.
- The owner's rdata SHALL be registered mem_rdata (loads and fetches) or 0 (stores), with err=0.
REQ-010 In RESP without mem_resp_valid, the counter SHALL increment. When it equals TIMEOUT-1, the FSM SHALL return to IDLE and the owner SHALL get a one-cycle resp_valid with err=1 and rdata=0.
REQ-011 If mem_resp_valid and timeout coincide, the response SHALL win (err=0).
REQ-012 mem_resp_valid outside RESP SHALL be ignored, including late responses after a timeout.
REQ-013 The non-owner's resp_valid SHALL stay 0. A new request SHALL be acceptable in the same cycle its predecessor's resp_valid pulses.
REQ-014 Minimum latency SHALL be: accept in cycle N, mem_req_valid in cycle N+1, mem_resp_valid sampled in cycle N+2 at the earliest, resp_valid in cycle N+3.
REQ-015 rdata/err outputs SHALL hold their last value between pulses.

Reset
REQ-016 On rst, the block SHALL set:
- state=IDLE, owner=IF, last-grant=IF (so LS wins the first tie), counter=0;
- all resp_valid/err=0, rdata=0, mem_* registers=0.
REQ-017 rst asserted mid-transaction SHALL drop the transaction with no response pulse. A memory response arriving after reset SHALL be ignored per REQ-012.

Structure
REQ-018 Package ysyx_22040127_arb_pkg SHALL hold:
- the state enum (IDLE/REQ/RESP);
- the owner enum (IF/LS);
- the TIMEOUT default constant.
REQ-019 The 2-way round-robin grant logic SHALL be sub-module ysyx_22040127_rr_arb2 (inputs: two valids, last-grant; output: one-hot grant).
REQ-020 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-021 Single load: ls_addr=0x80000010, ls_we=0, accepted in cycle 0; mem_req_ready=1 in cycle 1; mem_resp_valid=1 with mem_rdata=0xDEADBEEF_00000013 in cycle 2 -> in cycle 3, ls_resp_valid=1, ls_rdata=0xDEADBEEF_00000013, ls_resp_err=0, if_resp_valid=0.
REQ-022 Tie after reset: both valid in cycle 0 -> LS granted first; IF granted in the first IDLE after LS completes; with both valid again, LS is granted next (alternation).
REQ-023 Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid held for 6 cycles with mem_addr, mem_wdata and mem_wmask unchanged; both req_ready=0 throughout.
REQ-024 Store: ls_we=1, ls_wmask=0x0F, ls_wdata=0x1122334455667788 -> mem_we=1, mem_wmask=0x0F, mem_wdata as driven; ack -> ls_resp_valid pulse with ls_rdata=0.
REQ-025 Timeout: TIMEOUT=4 and no mem_resp_valid -> if_resp_valid=1, if_resp_err=1 exactly 4 cycles after entering RESP; a mem_resp_valid 2 cycles later produces no pulse.
REQ-026 Reset in RESP: rst for 1 cycle -> next cycle is IDLE with no resp pulse, and a subsequent tie grants LS.
